gmii_video_rx: RTL and testbench



---
 rtl/gmii_video_rx.sv | 108 ++++++++++
 tb/tb_gmii_video_rx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/gmii_video_rx.sv
// gmii_video_rx: GMII receive filter for Ethernet/IPv4/UDP video packets, unpacking the payload into pixel FIFO words.
module gmii_video_rx #(
  parameter logic [31:0] IPV4_DST      = 32'hC0A8_0001,
  parameter bit          CHECK_IP_DST  = 1'b0,
  parameter logic [15:0] DST_PORT      = 16'd12345,
  parameter logic [15:0] ETH_TYPE      = 16'h0800,
  parameter logic [7:0]  IP_VER        = 8'h45,
  parameter logic [7:0]  IP_PROTO      = 8'h11,
  parameter int          PIX_BYTES     = 2,
  parameter int          Y_BITS        = 11,
  parameter int          PAYLOAD_WORDS = 640
)(
  input  logic                          clk125,
  input  logic                          sys_rst,
  input  logic [7:0]                    rxd,
  input  logic                          rx_dv,
  input  logic                          rx_er,
  output logic [Y_BITS+8*PIX_BYTES:0]   datain,
  output logic                          recv_en,
  output logic                          packet_en,
  output logic                          line_done,
  output logic                          frame_err,
  output logic [15:0]                   pkt_ok_cnt,
  output logic [15:0]                   pkt_drop_cnt
);
  localparam int PW = 8*PIX_BYTES;
  typedef enum logic [2:0] {WAIT_IDLE, IDLE, HEADER, PAYLOAD, DROP} state_t;
  state_t r_state, w_next;
  logic [5:0] r_idx;
  logic [1:0] r_bcnt;
  logic [15:0] r_wcnt, r_ok_cnt, r_drop_cnt;
  logic [7:0] r_ylo, w_ip_byte;
  logic [Y_BITS-1:0] r_y;
  logic r_field, r_bad, r_recv_en, r_line_done, r_frame_err;
  logic [PW-1:0] r_pix, w_pix;
  logic [Y_BITS+PW:0] r_datain;
  logic w_in_frame, w_abort_dv, w_abort_er, w_ip_mis, w_mis, w_hdr_end, w_line_hdr;
  logic w_word, w_word_end, w_pkt_end, w_drop;
  always_comb begin
    w_in_frame = r_state == HEADER || r_state == PAYLOAD;
    w_abort_dv = w_in_frame && !rx_dv;
    w_abort_er = w_in_frame && rx_dv && rx_er;
    w_ip_byte  = r_idx == 6'd30 ? IPV4_DST[31:24] : r_idx == 6'd31 ? IPV4_DST[23:16] :
                 r_idx == 6'd32 ? IPV4_DST[15:8] : IPV4_DST[7:0];
    w_ip_mis   = CHECK_IP_DST && r_idx >= 6'd30 && r_idx <= 6'd33 && rxd != w_ip_byte;
    w_mis      = (r_idx == 6'd12 && rxd != ETH_TYPE[15:8]) || (r_idx == 6'd13 && rxd != ETH_TYPE[7:0]) ||
                 (r_idx == 6'd14 && rxd != IP_VER) || (r_idx == 6'd23 && rxd != IP_PROTO) ||
                 (r_idx == 6'd36 && rxd != DST_PORT[15:8]) || (r_idx == 6'd37 && rxd != DST_PORT[7:0]) || w_ip_mis;
    w_hdr_end  = r_state == HEADER && rx_dv && !rx_er && r_idx == 6'd42;
    w_line_hdr = r_state == PAYLOAD && rx_dv && !rx_er && r_idx == 6'd43;
    w_word     = r_state == PAYLOAD && rx_dv && !rx_er && r_idx != 6'd43;
    w_word_end = w_word && r_bcnt == 2'(PIX_BYTES-1);
    w_pkt_end  = w_word_end && r_wcnt == 16'(PAYLOAD_WORDS-1);
    w_drop     = w_abort_dv || w_abort_er || (w_hdr_end && r_bad);
    w_pix      = PW'({r_pix, rxd});
    w_next     = r_state;
    case (r_state)
      WAIT_IDLE: w_next = rx_dv ? WAIT_IDLE : IDLE;
      IDLE:      w_next = rx_dv && rxd == 8'hD5 ? HEADER : IDLE;
      HEADER:    w_next = !rx_dv ? IDLE : rx_er ? DROP : r_idx == 6'd42 ? (r_bad ? DROP : PAYLOAD) : HEADER;
      PAYLOAD:   w_next = !rx_dv ? IDLE : (rx_er || w_pkt_end) ? DROP : PAYLOAD;
      DROP:      w_next = rx_dv ? DROP : IDLE;
      default:   w_next = WAIT_IDLE;
    endcase
  end
  always_ff @(posedge clk125) begin
    if (sys_rst) begin
      r_state     <= WAIT_IDLE;
      r_idx       <= '0;
      r_bcnt      <= '0;
      r_wcnt      <= '0;
      r_ok_cnt    <= '0;
      r_drop_cnt  <= '0;
      r_ylo       <= '0;
      r_y         <= '0;
      r_field     <= 1'b0;
      r_bad       <= 1'b0;
      r_pix       <= '0;
      r_datain    <= '0;
      r_recv_en   <= 1'b0;
      r_line_done <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_idx       <= r_state == IDLE ? 6'd0 : (w_in_frame && r_idx != 6'd44) ? r_idx + 6'd1 : r_idx;
      r_bad       <= r_state == HEADER ? r_bad | w_mis : 1'b0;
      r_bcnt      <= (r_state != PAYLOAD || w_word_end) ? 2'd0 : r_bcnt + 2'(w_word);
      r_wcnt      <= r_state != PAYLOAD ? 16'd0 : r_wcnt + 16'(w_word_end);
      r_ylo       <= w_hdr_end ? rxd : r_ylo;
      r_y         <= w_line_hdr ? Y_BITS'({rxd[3:0], r_ylo}) : r_y;
      r_field     <= w_line_hdr ? rxd[4] : r_field;
      r_pix       <= w_word ? w_pix : r_pix;
      r_datain    <= w_word_end ? {r_field, r_y, w_pix} : r_datain;
      r_recv_en   <= w_word_end;
      r_line_done <= w_pkt_end;
      r_frame_err <= w_abort_dv || w_abort_er;
      r_ok_cnt    <= r_ok_cnt + 16'(w_pkt_end && r_ok_cnt != 16'hFFFF);
      r_drop_cnt  <= r_drop_cnt + 16'(w_drop && r_drop_cnt != 16'hFFFF);
    end
  end
  assign datain       = r_datain;
  assign recv_en      = r_recv_en;
  assign packet_en    = r_state == PAYLOAD;
  assign line_done    = r_line_done;
  assign frame_err    = r_frame_err;
  assign pkt_ok_cnt   = r_ok_cnt;
  assign pkt_drop_cnt = r_drop_cnt;
endmodule

// File: tb/tb_gmii_video_rx.sv
// tb_gmii_video_rx: directed frame vectors for gmii_video_rx at P=2, IP-checking, P=3 and P=4 configurations.
module tb_gmii_video_rx;
  logic clk125 = 1'b0, sys_rst = 1'b1, rx_dv = 1'b0, rx_er = 1'b0;
  logic [7:0] rxd = 8'h00;
  logic [27:0] d2_data, di_data;
  logic [35:0] d3_data;
  logic [43:0] d4_data;
  logic d2_re, d2_pe, d2_ld, d2_fe, di_re, di_pe, di_ld, di_fe;
  logic d3_re, d3_pe, d3_ld, d3_fe, d4_re, d4_pe, d4_ld, d4_fe;
  logic [15:0] d2_ok, d2_drop, di_ok, di_drop, d3_ok, d3_drop, d4_ok, d4_drop;
  gmii_video_rx #(.PIX_BYTES(2), .PAYLOAD_WORDS(4)) dut (.clk125(clk125), .sys_rst(sys_rst), .rxd(rxd), .rx_dv(rx_dv),
    .rx_er(rx_er), .datain(d2_data), .recv_en(d2_re), .packet_en(d2_pe), .line_done(d2_ld), .frame_err(d2_fe),
    .pkt_ok_cnt(d2_ok), .pkt_drop_cnt(d2_drop));
  gmii_video_rx #(.PIX_BYTES(2), .PAYLOAD_WORDS(4), .CHECK_IP_DST(1'b1)) dip (.clk125(clk125), .sys_rst(sys_rst),
    .rxd(rxd), .rx_dv(rx_dv), .rx_er(rx_er), .datain(di_data), .recv_en(di_re), .packet_en(di_pe), .line_done(di_ld),
    .frame_err(di_fe), .pkt_ok_cnt(di_ok), .pkt_drop_cnt(di_drop));
  gmii_video_rx #(.PIX_BYTES(3), .PAYLOAD_WORDS(2)) d3 (.clk125(clk125), .sys_rst(sys_rst), .rxd(rxd), .rx_dv(rx_dv),
    .rx_er(rx_er), .datain(d3_data), .recv_en(d3_re), .packet_en(d3_pe), .line_done(d3_ld), .frame_err(d3_fe),
    .pkt_ok_cnt(d3_ok), .pkt_drop_cnt(d3_drop));
  gmii_video_rx #(.PIX_BYTES(4), .PAYLOAD_WORDS(2)) d4 (.clk125(clk125), .sys_rst(sys_rst), .rxd(rxd), .rx_dv(rx_dv),
    .rx_er(rx_er), .datain(d4_data), .recv_en(d4_re), .packet_en(d4_pe), .line_done(d4_ld), .frame_err(d4_fe),
    .pkt_ok_cnt(d4_ok), .pkt_drop_cnt(d4_drop));
  always #4 clk125 = ~clk125;
  int total = 0, bad = 0;
  logic [63:0] q2[$], q3[$], q4[$];
  int ld2 = 0, ld3 = 0, ld4 = 0, err2 = 0, pe2 = 0;
  logic [7:0] fb[0:63];
  typedef struct {
    logic [15:0] dport; logic [7:0] oct; int cut; int er; logic [11:0] y; logic [3:0] x;
    int words; int ld; int dok; int ddrop; int err; int pe; int iok; int idrop;
  } vec_t;
  vec_t v[6];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  function automatic logic [7:0] pay(input int i);
    return i < 8 ? 8'(17*(i+1)) : 8'(8'h90 + i);
  endfunction
  function automatic logic [63:0] exp2(input int k, input logic [11:0] y, input logic [3:0] x);
    return {36'h0, x[0], y[10:0], pay(2*k), pay(2*k+1)};
  endfunction
  task automatic build(input logic [15:0] dport, input logic [7:0] oct, input logic [11:0] y, input logic [3:0] x);
    for (int i = 0; i < 64; i++) fb[i] = 8'h00;
    for (int i = 0; i < 7; i++) fb[i] = 8'h55;
    fb[7] = 8'hD5;
    fb[8+12] = 8'h08; fb[8+14] = 8'h45; fb[8+23] = 8'h11;
    fb[8+30] = 8'hC0; fb[8+31] = 8'hA8; fb[8+32] = oct; fb[8+33] = 8'h01;
    fb[8+36] = dport[15:8]; fb[8+37] = dport[7:0];
    fb[8+42] = y[7:0]; fb[8+43] = {x, y[11:8]};
    for (int i = 0; i < 8; i++) fb[8+44+i] = pay(i);
    fb[60] = 8'hDE; fb[61] = 8'hAD; fb[62] = 8'hBE; fb[63] = 8'hEF;
  endtask
  task automatic drive(input logic dv, input logic [7:0] d, input logic er);
    @(posedge clk125); #1;
    rx_dv = dv; rxd = d; rx_er = er;
  endtask
  task automatic send(input int cut, input int er_idx);
    for (int i = 0; i < 64; i++) begin
      if (cut >= 0 && i - 8 == 44 + cut) break;
      drive(1'b1, fb[i], i - 8 == er_idx);
    end
    drive(1'b0, 8'h00, 1'b0);
  endtask
  task automatic settle();
    repeat (3) @(posedge clk125);
    #2;
  endtask
  always @(negedge clk125) begin
    if (d2_re) q2.push_back(64'(d2_data));
    if (d3_re) q3.push_back(64'(d3_data));
    if (d4_re) q4.push_back(64'(d4_data));
    if (d2_ld) begin
      ld2++;
      chk("ld_with_recv_en", 64'(d2_re), 64'd1);
    end
    if (d3_ld) ld3++;
    if (d4_ld) ld4++;
    if (d2_fe) err2++;
    if (d2_pe) pe2++;
  end
  initial begin
    int qb, q3b, q4b, lb, l3b, l4b, eb, pb;
    logic [15:0] ob, db, iob, idb;
    v[0] = '{16'd12345, 8'd0,  -1, -1, 12'h123, 4'h1, 4, 1, 1, 0, 0, 1, 1, 0};
    v[1] = '{16'd12346, 8'd0,  -1, -1, 12'h123, 4'h1, 0, 0, 0, 1, 0, 0, 0, 1};
    v[2] = '{16'd12345, 8'd10, -1, -1, 12'h123, 4'h1, 4, 1, 1, 0, 0, 1, 0, 1};
    v[3] = '{16'd12345, 8'd0,   3, -1, 12'h123, 4'h1, 1, 0, 0, 1, 1, 1, 0, 1};
    v[4] = '{16'd12345, 8'd0,  -1, 50, 12'h123, 4'h1, 3, 0, 0, 1, 1, 1, 0, 1};
    v[5] = '{16'd12345, 8'd0,  -1, -1, 12'hABC, 4'h2, 4, 1, 1, 0, 0, 1, 1, 0};
    repeat (3) @(negedge clk125);
    chk("rst_datain", 64'(d2_data), 64'd0);
    chk("rst_recv_en", 64'(d2_re), 64'd0);
    chk("rst_packet_en", 64'(d2_pe), 64'd0);
    chk("rst_line_done", 64'(d2_ld), 64'd0);
    chk("rst_frame_err", 64'(d2_fe), 64'd0);
    chk("rst_ok_cnt", 64'(d2_ok), 64'd0);
    chk("rst_drop_cnt", 64'(d2_drop), 64'd0);
    @(posedge clk125); #1;
    sys_rst = 1'b0;
    repeat (2) @(posedge clk125);
    for (int r = 0; r < 6; r++) begin
      qb = q2.size(); lb = ld2; eb = err2; pb = pe2; ob = d2_ok; db = d2_drop; iob = di_ok; idb = di_drop;
      build(v[r].dport, v[r].oct, v[r].y, v[r].x);
      send(v[r].cut, v[r].er);
      settle();
      chk($sformatf("r%0d_words", r), 64'(q2.size() - qb), 64'(v[r].words));
      for (int k = 0; k < v[r].words && qb + k < q2.size(); k++)
        chk($sformatf("r%0d_word%0d", r, k), q2[qb+k], exp2(k, v[r].y, v[r].x));
      chk($sformatf("r%0d_line_done", r), 64'(ld2 - lb), 64'(v[r].ld));
      chk($sformatf("r%0d_ok_cnt", r), 64'(16'(d2_ok - ob)), 64'(v[r].dok));
      chk($sformatf("r%0d_drop_cnt", r), 64'(16'(d2_drop - db)), 64'(v[r].ddrop));
      chk($sformatf("r%0d_frame_err", r), 64'(err2 - eb), 64'(v[r].err));
      chk($sformatf("r%0d_packet_en", r), 64'(pe2 > pb), 64'(v[r].pe));
      chk($sformatf("r%0d_ipchk_ok", r), 64'(16'(di_ok - iob)), 64'(v[r].iok));
      chk($sformatf("r%0d_ipchk_drop", r), 64'(16'(di_drop - idb)), 64'(v[r].idrop));
    end
    qb = q2.size(); eb = err2; ob = d2_ok; db = d2_drop;
    build(16'd12345, 8'd0, 12'h123, 4'h1);
    send(-1, 50);
    build(16'd12345, 8'd0, 12'h055, 4'h3);
    send(-1, -1);
    settle();
    chk("b2b_words", 64'(q2.size() - qb), 64'd7);
    for (int k = 0; k < 4 && qb + 3 + k < q2.size(); k++)
      chk($sformatf("b2b_word%0d", k), q2[qb+3+k], exp2(k, 12'h055, 4'h3));
    chk("b2b_ok_cnt", 64'(16'(d2_ok - ob)), 64'd1);
    chk("b2b_drop_cnt", 64'(16'(d2_drop - db)), 64'd1);
    chk("b2b_frame_err", 64'(err2 - eb), 64'd1);
    q3b = q3.size(); q4b = q4.size(); l3b = ld3; l4b = ld4;
    build(16'd12345, 8'd0, 12'h123, 4'h1);
    send(-1, -1);
    settle();
    chk("p3_words", 64'(q3.size() - q3b), 64'd2);
    chk("p4_words", 64'(q4.size() - q4b), 64'd2);
    if (q3.size() - q3b == 2) begin
      chk("p3_word0", q3[q3b], 64'({1'b1, 11'h123, 24'h112233}));
      chk("p3_word1", q3[q3b+1], 64'({1'b1, 11'h123, 24'h445566}));
    end
    if (q4.size() - q4b == 2) begin
      chk("p4_word0", q4[q4b], 64'({1'b1, 11'h123, 32'h11223344}));
      chk("p4_word1", q4[q4b+1], 64'({1'b1, 11'h123, 32'h55667788}));
    end
    chk("p3_line_done", 64'(ld3 - l3b), 64'd1);
    chk("p4_line_done", 64'(ld4 - l4b), 64'd1);
    build(16'd12345, 8'd0, 12'h123, 4'h1);
    for (int i = 0; i <= 8 + 46; i++) drive(1'b1, fb[i], 1'b0);
    drive(1'b1, fb[8+47], 1'b0);
    sys_rst = 1'b1;
    drive(1'b1, 8'hD5, 1'b0);
    sys_rst = 1'b0;
    qb = q2.size(); eb = err2; pb = pe2;
    repeat (6) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    repeat (20) drive(1'b1, 8'h11, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    settle();
    chk("rst_mid_words", 64'(q2.size() - qb), 64'd0);
    chk("rst_mid_ok_cnt", 64'(d2_ok), 64'd0);
    chk("rst_mid_drop_cnt", 64'(d2_drop), 64'd0);
    chk("rst_mid_frame_err", 64'(err2 - eb), 64'd0);
    chk("rst_mid_packet_en", 64'(pe2 - pb), 64'd0);
    chk("rst_mid_datain", 64'(d2_data), 64'd0);
    qb = q2.size();
    build(16'd12345, 8'd0, 12'h321, 4'h0);
    send(-1, -1);
    settle();
    chk("post_rst_words", 64'(q2.size() - qb), 64'd4);
    if (q2.size() - qb == 4) chk("post_rst_word3", q2[qb+3], exp2(3, 12'h321, 4'h0));
    chk("post_rst_ok_cnt", 64'(d2_ok), 64'd1);
    force dut.r_ok_cnt = 16'hFFFE;
    force dut.r_drop_cnt = 16'hFFFE;
    @(posedge clk125); #1;
    release dut.r_ok_cnt;
    release dut.r_drop_cnt;
    @(posedge clk125); #2;
    chk("sat_preload_ok", 64'(d2_ok), 64'hFFFE);
    build(16'd12345, 8'd0, 12'h123, 4'h1);
    send(-1, -1);
    settle();
    chk("sat_ok_1", 64'(d2_ok), 64'hFFFF);
    send(-1, -1);
    settle();
    chk("sat_ok_2", 64'(d2_ok), 64'hFFFF);
    build(16'd12346, 8'd0, 12'h123, 4'h1);
    send(-1, -1);
    settle();
    chk("sat_drop_1", 64'(d2_drop), 64'hFFFF);
    send(-1, -1);
    settle();
    chk("sat_drop_2", 64'(d2_drop), 64'hFFFF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
